// File: rtl/stall_aware_producer_if.sv
// Producer-side bundle: per-lane data/valid/flush toward the pipeline, stall coming back.
interface stall_aware_producer_if #(
  parameter int DATA_W = 32
);
  logic              stall_1;
  logic              stall_2;
  logic [DATA_W-1:0] pipeline1_inputs;
  logic [DATA_W-1:0] pipeline2_inputs;
  logic [1:0]        in_valid;
  logic              flush_1;
  logic              flush_2;
  logic              done;

  modport master (
    input  stall_1, stall_2,
    output pipeline1_inputs, pipeline2_inputs, in_valid, flush_1, flush_2, done
  );

  modport slave (
    output stall_1, stall_2,
    input  pipeline1_inputs, pipeline2_inputs, in_valid, flush_1, flush_2, done
  );
endinterface

// File: rtl/stall_aware_producer.sv
// Dual-lane sequence producer: each lane emits NUM_ITEMS words, holds under stall,
// and inserts a one-cycle flush after every FLUSH_PERIOD-th accepted word.
module stall_aware_producer_lane #(
  parameter int                DATA_W       = 32,
  parameter int                NUM_ITEMS    = 16,
  parameter int                FLUSH_PERIOD = 5,
  parameter logic [DATA_W-1:0] SEQ_BASE     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_flush,
  output logic              o_done_nxt
);
  localparam int CNT_W   = $clog2(NUM_ITEMS + 1);
  localparam int FP_SAFE = (FLUSH_PERIOD == 0) ? 1 : FLUSH_PERIOD;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FLUSH, S_DONE} state_t;

  state_t            r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_sent, w_nxt_sent, w_sent_inc;
  logic [DATA_W-1:0] r_data, w_nxt_data;
  logic              r_valid, w_nxt_valid;
  logic              r_flush, w_nxt_flush;

  assign w_sent_inc = r_sent + CNT_W'(1);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sent  = r_sent;
    w_nxt_data  = r_data;
    w_nxt_valid = r_valid;
    w_nxt_flush = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_state = S_SEND;
        w_nxt_data  = SEQ_BASE;
        w_nxt_valid = 1'b1;
      end
      S_SEND: begin
        if (!i_stall) begin
          w_nxt_sent = w_sent_inc;
          if (w_sent_inc == CNT_W'(NUM_ITEMS)) begin
            w_nxt_state = S_DONE;
            w_nxt_valid = 1'b0;
          end else if (FLUSH_PERIOD != 0 &&
                       (32'(w_sent_inc) % 32'(FP_SAFE)) == 32'd0) begin
            w_nxt_state = S_FLUSH;
            w_nxt_valid = 1'b0;
            w_nxt_flush = 1'b1;
          end else begin
            w_nxt_data  = SEQ_BASE + DATA_W'(w_sent_inc);
            w_nxt_valid = 1'b1;
          end
        end
      end
      // Stall is deliberately ignored here so the flush pulse is never stretched.
      S_FLUSH: begin
        w_nxt_state = S_SEND;
        w_nxt_data  = SEQ_BASE + DATA_W'(r_sent);
        w_nxt_valid = 1'b1;
      end
      default: begin
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sent  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_sent  <= w_nxt_sent;
      r_data  <= w_nxt_data;
      r_valid <= w_nxt_valid;
      r_flush <= w_nxt_flush;
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_flush    = r_flush;
  // Next-state view lets the top register done in the same cycle both lanes enter DONE.
  assign o_done_nxt = (w_nxt_state == S_DONE);
endmodule

module stall_aware_producer #(
  parameter int                DATA_W       = 32,
  parameter int                NUM_ITEMS    = 16,
  parameter int                FLUSH_PERIOD = 5,
  parameter logic [DATA_W-1:0] SEQ_BASE_1   = 32'h0000_1000,
  parameter logic [DATA_W-1:0] SEQ_BASE_2   = 32'h0000_2000
) (
  input  logic                   clk,
  input  logic                   reset,
  stall_aware_producer_if.master bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             w_stall, w_valid, w_flush, w_done_nxt;
  logic [NUM_LANES-1:0][DATA_W-1:0] w_data;
  logic                             r_done;

  assign w_stall = {bus.stall_2, bus.stall_1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [DATA_W-1:0] BASE = (g == 0) ? SEQ_BASE_1 : SEQ_BASE_2;
    stall_aware_producer_lane #(
      .DATA_W(DATA_W), .NUM_ITEMS(NUM_ITEMS),
      .FLUSH_PERIOD(FLUSH_PERIOD), .SEQ_BASE(BASE)
    ) u_lane (
      .clk       (clk),
      .rst_n     (reset),
      .i_stall   (w_stall[g]),
      .o_data    (w_data[g]),
      .o_valid   (w_valid[g]),
      .o_flush   (w_flush[g]),
      .o_done_nxt(w_done_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= &w_done_nxt;
  end

  assign bus.pipeline1_inputs = w_data[0];
  assign bus.pipeline2_inputs = w_data[1];
  assign bus.in_valid         = w_valid;
  assign bus.flush_1          = w_flush[0];
  assign bus.flush_2          = w_flush[1];
  assign bus.done             = r_done;
endmodule

// File: tb/tb_stall_aware_producer.sv
// Bench for stall_aware_producer: vector table, hand sequences and a slot-list reference model.
module tb_stall_aware_producer;
  localparam int DW = 32;
  localparam int N  = 16;
  localparam int FP = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stall_aware_producer_if #(.DATA_W(DW)) bus ();
  stall_aware_producer_if #(.DATA_W(DW)) bus0 ();

  stall_aware_producer #(.DATA_W(DW), .NUM_ITEMS(N), .FLUSH_PERIOD(FP),
    .SEQ_BASE_1(32'h1000), .SEQ_BASE_2(32'h2000))
    dut (.clk(clk), .reset(reset), .bus(bus));

  stall_aware_producer #(.DATA_W(DW), .NUM_ITEMS(N), .FLUSH_PERIOD(0),
    .SEQ_BASE_1(32'h1000), .SEQ_BASE_2(32'h2000))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int checks = 0;
  int errors = 0;

  // Reference model: each lane's output is a list of slots (item index, or -1 for flush).
  int      slots[2][$];
  int      midx[2];
  bit      mstart;
  logic [31:0] acc[2][$];
  int ncyc, fv1, dn1, fv0, dn0, fl1, fl2;

  typedef struct {
    logic s1, s2;
    logic [1:0] v;
    logic f1, f2;
    logic [31:0] d1, d2;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [31:0] lbase(input int l);
    return (l == 0) ? 32'h1000 : 32'h2000;
  endfunction

  task automatic build_slots();
    for (int l = 0; l < 2; l++) begin
      slots[l].delete();
      for (int k = 0; k < N; k++) begin
        slots[l].push_back(k);
        if (k + 1 < N && FP != 0 && (k + 1) % FP == 0) slots[l].push_back(-1);
      end
    end
  endtask

  task automatic model_step(input logic s1, input logic s2);
    logic [1:0] st;
    st = {s2, s1};
    if (!mstart) begin
      mstart = 1'b1;
      midx[0] = 0;
      midx[1] = 0;
    end else begin
      for (int l = 0; l < 2; l++)
        if (midx[l] < slots[l].size() && (slots[l][midx[l]] < 0 || !st[l])) midx[l]++;
    end
  endtask

  task automatic model_check();
    logic ev, ef, av, af;
    logic [31:0] ed, ad;
    logic [1:0] ld;
    ld = 2'b00;
    for (int l = 0; l < 2; l++) begin
      ev = 1'b0; ef = 1'b0; ed = '0;
      if (mstart) begin
        if (midx[l] == slots[l].size()) begin
          ld[l] = 1'b1;
          ed = lbase(l) + 32'(N - 1);
        end else if (slots[l][midx[l]] < 0) ef = 1'b1;
        else begin
          ev = 1'b1;
          ed = lbase(l) + 32'(slots[l][midx[l]]);
        end
      end
      av = bus.in_valid[l];
      af = (l == 0) ? bus.flush_1 : bus.flush_2;
      ad = (l == 0) ? bus.pipeline1_inputs : bus.pipeline2_inputs;
      chk($sformatf("m_valid%0d", l + 1), av, ev);
      chk($sformatf("m_flush%0d", l + 1), af, ef);
      if (ev || ld[l] || !mstart) chk($sformatf("m_data%0d", l + 1), ad, ed);
    end
    chk("m_done", bus.done, &ld);
    chk("fp0_noflush", {bus0.flush_2, bus0.flush_1}, 2'b00);
  endtask

  task automatic cyc(input logic s1, input logic s2);
    bus.stall_1 = s1;
    bus.stall_2 = s2;
    if (bus.in_valid[0] && !s1) acc[0].push_back(bus.pipeline1_inputs);
    if (bus.in_valid[1] && !s2) acc[1].push_back(bus.pipeline2_inputs);
    @(posedge clk);
    ncyc++;
    model_step(s1, s2);
    #1;
    if (fv1 < 0 && bus.in_valid != 2'b00) fv1 = ncyc;
    if (dn1 < 0 && bus.done) dn1 = ncyc;
    if (fv0 < 0 && bus0.in_valid != 2'b00) fv0 = ncyc;
    if (dn0 < 0 && bus0.done) dn0 = ncyc;
    if (bus.flush_1) fl1++;
    if (bus.flush_2) fl2++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d1"}, bus.pipeline1_inputs, 0);
    chk({tag, "_d2"}, bus.pipeline2_inputs, 0);
    chk({tag, "_v"}, bus.in_valid, 0);
    chk({tag, "_f"}, {bus.flush_2, bus.flush_1}, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_fp0"}, {bus0.in_valid, bus0.done}, 0);
  endtask

  // Asserts reset away from the clock edge, checks outputs clear immediately, then releases.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1 chk_zero("rst_hold");
    mstart = 1'b0;
    acc[0].delete();
    acc[1].delete();
    ncyc = 0; fv1 = -1; dn1 = -1; fv0 = -1; dn0 = -1; fl1 = 0; fl2 = 0;
    bus.stall_1 = 1'b0;
    bus.stall_2 = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic sb_check(input string tag);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_count%0d", tag, l + 1), acc[l].size(), N);
      for (int k = 0; k < acc[l].size() && k < N; k++)
        chk($sformatf("%s_word%0d_%0d", tag, l + 1, k), acc[l][k], lbase(l) + 32'(k));
    end
  endtask

  initial begin
    bus.stall_1 = 1'b0; bus.stall_2 = 1'b0;
    bus0.stall_1 = 1'b0; bus0.stall_2 = 1'b0;
    ncyc = 0; fv1 = -1; dn1 = -1; fv0 = -1; dn0 = -1; fl1 = 0; fl2 = 0;
    mstart = 1'b0;
    build_slots();

    tbl[0] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1000, 32'h2000};
    tbl[1] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1001, 32'h2001};
    tbl[2] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1002, 32'h2002};
    tbl[3] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1002, 32'h2003};
    tbl[4] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1002, 32'h2004};
    tbl[5] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h1002, 32'h0000};
    tbl[6] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1002, 32'h2005};
    tbl[7] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1003, 32'h2006};
    tbl[8] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h1004, 32'h2007};

    #1;
    do_reset();

    // Stall lane 1 while it presents 0x1002; lane 2 runs through its first flush.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s1, tbl[i].s2);
      chk($sformatf("tv%0d_valid", i), bus.in_valid, tbl[i].v);
      chk($sformatf("tv%0d_flush1", i), bus.flush_1, tbl[i].f1);
      chk($sformatf("tv%0d_flush2", i), bus.flush_2, tbl[i].f2);
      if (tbl[i].v[0]) chk($sformatf("tv%0d_d1", i), bus.pipeline1_inputs, tbl[i].d1);
      if (tbl[i].v[1]) chk($sformatf("tv%0d_d2", i), bus.pipeline2_inputs, tbl[i].d2);
      model_check();
    end

    // Mid-cycle reset while lane 2 presents 0x2007, then stall during lane 1's flush.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0);
      model_check();
    end
    chk("restart_first", {fv1, fv0}, {32'd1, 32'd1});
    chk("c_flush_on", {bus.flush_1, bus.in_valid[0]}, 2'b10);
    cyc(1'b1, 1'b0);
    model_check();
    chk("c_flush_off", bus.flush_1, 1'b0);
    chk("c_hold_a", {bus.in_valid[0], bus.pipeline1_inputs}, {1'b1, 32'h1005});
    cyc(1'b1, 1'b0);
    model_check();
    chk("c_hold_b", {bus.in_valid[0], bus.pipeline1_inputs}, {1'b1, 32'h1005});
    cyc(1'b0, 1'b0);
    model_check();
    chk("c_next", {bus.in_valid[0], bus.pipeline1_inputs}, {1'b1, 32'h1006});
    chk("c_flush_cnt", fl1, 1);

    // Stall-free run: latency to done, flush count, and both flush-period settings.
    do_reset();
    for (int k = 0; k < 100 && !(bus.done && bus0.done); k++) begin
      cyc(1'b0, 1'b0);
      model_check();
    end
    chk("d_done", {bus.done, bus0.done}, 2'b11);
    chk("d_latency", dn1 - fv1, 19);
    chk("d_latency_fp0", dn0 - fv0, 16);
    chk("d_flushes", {fl1, fl2}, {32'd3, 32'd3});
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0);
      model_check();
    end
    sb_check("d_sb");

    // Random stalls on both lanes against the model and an accept scoreboard.
    do_reset();
    for (int k = 0; k < 600 && !bus.done; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_check();
    end
    chk("e_done", bus.done, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_check();
    end
    sb_check("e_sb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
